avmm_mem_responder: RTL and testbench
=====================================

Name: avmm_mem_responder

Overview:
Parametrised, synthesizable Avalon-MM pipelined burst slave with word-addressed memory behind it. It is the next-generation slave model for the bpfcap benches: it stands in for the host memory that the capture engine writes packets into, and for the register space that software reads back. It also runs on FPGA as a scratch buffer. Data width, depth, read latency, burst length and outstanding-read depth are all configurable, and it adds sticky error flags and traffic counters.

Parameters:
DATA_W, 32, data bus width in bits (multiple of 8)
ADDR_W, 10, word address width
DEPTH, 1024, memory words (at most 2**ADDR_W)
RD_LATENCY, 2, cycles from read acceptance to the first readdatavalid (1..8)
MAX_BURST, 8, maximum burstcount (power of 2)
MAX_PENDING, 4, outstanding read commands held in the command FIFO

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  word address
avs_read  in  1  read request
avs_write  in  1  write request/beat
avs_writedata  in  DATA_W  write data
avs_byteenable  in  DATA_W/8  byte lane enables
avs_burstcount  in  $clog2(MAX_BURST)+1  burst length in beats
avs_waitrequest  out  1  stall; a command or beat transfers only when this is 0
avs_readdata  out  DATA_W  read data
avs_readdatavalid  out  1  read beat valid
rd_cmd_count  out  32  accepted read commands, saturating
wr_beat_count  out  32  accepted write beats, saturating
err_oob  out  1  sticky: address >= DEPTH seen
err_proto  out  1  sticky: burstcount 0 or > MAX_BURST, or read during an open write burst

Behaviour:
- Reset (reset_n low, async): all outputs 0 except avs_waitrequest=1. Command FIFO, latency pipe, write-burst state and counters are cleared. Memory contents are NOT cleared. avs_waitrequest drops to 0 on the first clk edge after release.
- Reset mid-burst: all in-flight readdatavalid beats are discarded. A partial write burst is abandoned; beats already written remain.
- Write FSM, states W_IDLE and W_BURST:
  - W_IDLE: write accepted with burstcount=1 -> one beat written, stay in W_IDLE.
  - W_IDLE: write accepted with burstcount>1 -> latch address+1 and remaining count, go to W_BURST.
  - W_BURST: each accepted write beat uses the internal address (avs_address is ignored) and decrements the count; return to W_IDLE after the last beat.
  - Byte lanes with byteenable=0 keep their old value. Write is visible to a read accepted in the next cycle.
- Read path:
  - An accepted read pushes {address, burstcount} into the command FIFO (depth MAX_PENDING).
  - The issue engine pops one command and emits one beat per cycle at consecutive addresses into a RD_LATENCY-stage shift pipe. The pipe output drives readdata/readdatavalid.
  - Back-to-back commands stream with no bubble. A single-beat read accepted at cycle t gives readdatavalid at t+RD_LATENCY.
- avs_waitrequest is combinational and = FIFO full OR (avs_read AND write FSM in W_BURST) OR stall_pattern.
  - FIFO full and a pop in the same cycle: the push is accepted (waitrequest=0).
- Addressing: addresses wrap modulo 2**ADDR_W inside a burst.
  - Write to an address >= DEPTH: beat dropped, err_oob set.
  - Read from an address >= DEPTH: returns 0, err_oob set.
- Protocol errors set err_proto:
  - burstcount 0 is treated as 1;
  - burstcount > MAX_BURST is clamped to MAX_BURST;
  - a read asserted while in W_BURST is stalled.
- Simultaneous read and write asserted in W_IDLE: the write is accepted, the read is stalled one cycle, and err_proto is set.
- Counters saturate at 32'hFFFF_FFFF.

Optional Feature:
AVMM_RESP_STALL_EN:
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle; stall_pattern = lfsr[1:0]==2'b00 (~25% backpressure).
- Undefined: stall_pattern is constant 0 and the LFSR is not instantiated.

Decomposition:
- Package avmm_pkg holds:
  - the write FSM state enum (W_IDLE, W_BURST);
  - the read command struct {addr, burstcount};
  - the LFSR seed/taps constants;
  - the out-of-range read value constant (all-zero).
- Sub-module avmm_cmd_fifo: parametrised synchronous FIFO with full/empty, reused elsewhere in bpfcap.

Test Plan:
- Single write of 32'hCAFE_0001 to addr 5, then a single read of addr 5 -> readdatavalid exactly RD_LATENCY=2 cycles after acceptance, readdata=32'hCAFE_0001, wr_beat_count=1, rd_cmd_count=1.
- Write burst of 4 at addr 8 (data 1,2,3,4, address held at 0 after the first beat), then read burst of 4 at addr 8 -> 4 consecutive valid beats 1,2,3,4.
- Byteenable 4'b0101 write of 32'hFFFF_FFFF over an existing 32'h0000_0000 -> readback 32'h00FF_00FF.
- Five single reads issued back-to-back while the pipe is busy, MAX_PENDING=4 -> waitrequest high on the cycle FIFO occupancy hits 4 with no pop; all 5 beats are eventually returned in order.
- Read at addr 1023 with burstcount 2, DEPTH=1000 -> both beats 0, err_oob=1. Then burstcount 0 -> err_proto=1 and one beat returned.
- Assert reset_n low mid read burst -> readdatavalid 0 immediately, counters 0; after release a read of a previously written address returns the original data.

Source files
------------

// File: rtl/avmm_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package avmm_pkg;

    typedef enum logic [0:0] {
        W_IDLE,
        W_BURST
    } wstate_t;

    // Fields are sized for the widest configuration; users slice them down.
    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_BC_W   = 8;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_BC_W-1:0]   burstcount;
    } rd_cmd_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic RD_OOB_FILL = 1'b0;

endpackage

// File: rtl/avmm_cmd_fifo.sv
// Parametrised synchronous FIFO with full/empty flags; push while full is
// accepted only when a pop happens in the same cycle.
module avmm_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign dout    = mem[rp];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push)
                wp <= (wp == PW'(DEPTH-1)) ? '0 : wp + PW'(1);
            if (do_pop)
                rp <= (rp == PW'(DEPTH-1)) ? '0 : rp + PW'(1);
            if (do_push && !do_pop)
                cnt <= cnt + (PW+1)'(1);
            else if (do_pop && !do_push)
                cnt <= cnt - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= din;
    end

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM pipelined burst slave over a word-addressed memory.
// Define AVMM_RESP_STALL_EN to add LFSR-driven pseudo-random backpressure.
module avmm_mem_responder
    import avmm_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned MAX_BURST   = 8,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          avs_address,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [DATA_W-1:0]          avs_writedata,
    input  logic [DATA_W/8-1:0]        avs_byteenable,
    input  logic [$clog2(MAX_BURST):0] avs_burstcount,
    output logic                       avs_waitrequest,
    output logic [DATA_W-1:0]          avs_readdata,
    output logic                       avs_readdatavalid,
    output logic [31:0]                rd_cmd_count,
    output logic [31:0]                wr_beat_count,
    output logic                       err_oob,
    output logic                       err_proto
);

    localparam int unsigned BC_W   = $clog2(MAX_BURST) + 1;
    localparam int unsigned MEM_AW = $clog2(DEPTH);
    localparam int unsigned BE_W   = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    wstate_t           wstate;
    logic [ADDR_W-1:0] wb_addr;
    logic [BC_W-1:0]   wb_left;
    logic              ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [BC_W-1:0]   rd_left;
    logic              pipe_v [RD_LATENCY];
    logic [DATA_W-1:0] pipe_d [RD_LATENCY];

    logic              stall;
    logic [BC_W-1:0]   eff_bc;
    logic              bc_bad;
    logic              busy;
    logic              acc_wr;
    logic              acc_rd;
    logic              direct;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    rd_cmd_t           fifo_din;
    rd_cmd_t           fifo_dout;
    logic              iss_v;
    logic              iss_new;
    logic [ADDR_W-1:0] iss_addr;
    logic [BC_W-1:0]   iss_bc;
    logic              iss_oob;
    logic [DATA_W-1:0] iss_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_oob;
    logic              unused_cmd_bits;

    assign unused_cmd_bits = ^{fifo_dout.addr[CMD_ADDR_W-1:ADDR_W],
                               fifo_dout.burstcount[CMD_BC_W-1:BC_W]};

`ifdef AVMM_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        bc_bad = (avs_burstcount == '0) || (avs_burstcount > BC_W'(MAX_BURST));
        if (avs_burstcount == '0)
            eff_bc = BC_W'(1);
        else if (avs_burstcount > BC_W'(MAX_BURST))
            eff_bc = BC_W'(MAX_BURST);
        else
            eff_bc = avs_burstcount;
    end

    // A full FIFO still takes a push when the issue engine pops in the same cycle.
    always_comb begin
        busy            = (rd_left != '0);
        fifo_pop        = !busy && !fifo_empty;
        avs_waitrequest = !ready || (fifo_full && !fifo_pop) ||
                          (avs_read && wstate == W_BURST) || stall;
        acc_wr          = avs_write && !avs_waitrequest;
        acc_rd          = avs_read && !avs_write && !avs_waitrequest;
        direct          = acc_rd && !busy && fifo_empty;
        fifo_push       = acc_rd && !direct;
        fifo_din.addr       = CMD_ADDR_W'(avs_address);
        fifo_din.burstcount = CMD_BC_W'(eff_bc);
    end

    // An idle engine with an empty FIFO issues a new read directly, so a
    // command reaches the latency pipe in the cycle it is accepted.
    always_comb begin
        iss_v    = 1'b0;
        iss_new  = 1'b0;
        iss_addr = rd_addr;
        iss_bc   = eff_bc;
        if (busy) begin
            iss_v = 1'b1;
        end else if (fifo_pop) begin
            iss_v    = 1'b1;
            iss_new  = 1'b1;
            iss_addr = fifo_dout.addr[ADDR_W-1:0];
            iss_bc   = fifo_dout.burstcount[BC_W-1:0];
        end else if (direct) begin
            iss_v    = 1'b1;
            iss_new  = 1'b1;
            iss_addr = avs_address;
        end
        iss_oob  = (CMD_ADDR_W'(iss_addr) >= DEPTH);
        iss_data = iss_oob ? {DATA_W{RD_OOB_FILL}} : mem[iss_addr[MEM_AW-1:0]];
        wr_addr  = (wstate == W_BURST) ? wb_addr : avs_address;
        wr_oob   = (CMD_ADDR_W'(wr_addr) >= DEPTH);
    end

    avmm_cmd_fifo #(
        .WIDTH ($bits(rd_cmd_t)),
        .DEPTH (MAX_PENDING)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready         <= 1'b0;
            wstate        <= W_IDLE;
            wb_addr       <= '0;
            wb_left       <= '0;
            rd_addr       <= '0;
            rd_left       <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
            rd_cmd_count  <= '0;
            wr_beat_count <= '0;
            err_oob       <= 1'b0;
            err_proto     <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (acc_wr) begin
                if (wstate == W_IDLE) begin
                    if (eff_bc > BC_W'(1)) begin
                        wb_addr <= avs_address + ADDR_W'(1);
                        wb_left <= eff_bc - BC_W'(1);
                        wstate  <= W_BURST;
                    end
                end else begin
                    wb_addr <= wb_addr + ADDR_W'(1);
                    wb_left <= wb_left - BC_W'(1);
                    if (wb_left == BC_W'(1))
                        wstate <= W_IDLE;
                end
            end
            if (iss_v) begin
                if (iss_new) begin
                    rd_addr <= iss_addr + ADDR_W'(1);
                    rd_left <= iss_bc - BC_W'(1);
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    rd_left <= rd_left - BC_W'(1);
                end
            end
            pipe_v[0] <= iss_v;
            pipe_d[0] <= iss_data;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            if (acc_rd && rd_cmd_count != '1)
                rd_cmd_count <= rd_cmd_count + 32'd1;
            if (acc_wr && wr_beat_count != '1)
                wr_beat_count <= wr_beat_count + 32'd1;
            if ((acc_wr && wr_oob) || (iss_v && iss_oob))
                err_oob <= 1'b1;
            if ((bc_bad && (acc_rd || (acc_wr && wstate == W_IDLE))) ||
                (ready && avs_read && wstate == W_BURST) ||
                (acc_wr && avs_read))
                err_proto <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_wr && !wr_oob) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (avs_byteenable[b])
                    mem[wr_addr[MEM_AW-1:0]][b*8 +: 8] <= avs_writedata[b*8 +: 8];
            end
        end
    end

    assign avs_readdatavalid = pipe_v[RD_LATENCY-1];
    assign avs_readdata      = pipe_d[RD_LATENCY-1];

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Directed bench for avmm_mem_responder with an in-bench memory/read-order model.
module tb_avmm_mem_responder;

    localparam int DEPTH  = 1000;
    localparam int ASPACE = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [3:0]  avs_burstcount = '0;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [31:0] rd_cmd_count;
    logic [31:0] wr_beat_count;
    logic        err_oob;
    logic        err_proto;

    avmm_mem_responder #(
        .DATA_W      (32),
        .ADDR_W      (10),
        .DEPTH       (DEPTH),
        .RD_LATENCY  (2),
        .MAX_BURST   (8),
        .MAX_PENDING (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_burstcount    (avs_burstcount),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .rd_cmd_count      (rd_cmd_count),
        .wr_beat_count     (wr_beat_count),
        .err_oob           (err_oob),
        .err_proto         (err_proto)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;
    int n_wr = 0;
    int n_rd = 0;
    logic [31:0] model_mem [ASPACE];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          got_cyc [$];
    int          wb_next = 0;
    int          wb_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int eff_bc(input logic [3:0] bc);
        if (bc == 4'd0) return 1;
        if (bc > 4'd8) return 8;
        return int'(bc);
    endfunction

    // Every returned beat must match the oldest outstanding model expectation.
    always @(negedge clk) begin
        if (reset_n && avs_readdatavalid) begin
            got_q.push_back(avs_readdata);
            got_cyc.push_back(cyc);
            if (exp_q.size() == 0)
                check("readdatavalid vs model", 32'(avs_readdatavalid), 32'd0);
            else
                check("readdata vs model", avs_readdata, exp_q.pop_front());
        end
    end

    task automatic wait_accept(output int acc_cyc, output int stalls);
        stalls  = 0;
        acc_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                return;
            end
            stalls++;
        end
        check("accept timeout waitrequest", 32'(avs_waitrequest), 32'd0);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be, input logic [3:0] bc);
        int acc, st, target;
        avs_address    = 10'(a);
        avs_writedata  = d;
        avs_byteenable = be;
        avs_burstcount = bc;
        avs_write      = 1'b1;
        wait_accept(acc, st);
        avs_write = 1'b0;
        n_wr++;
        if (wb_left == 0) begin
            target = a;
            if (eff_bc(bc) > 1) begin
                wb_left = eff_bc(bc) - 1;
                wb_next = (a + 1) % ASPACE;
            end
        end else begin
            target  = wb_next;
            wb_next = (wb_next + 1) % ASPACE;
            wb_left--;
        end
        if (target < DEPTH)
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[target][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic rd(input int a, input logic [3:0] bc, output int acc, output int st);
        int t;
        avs_address    = 10'(a);
        avs_burstcount = bc;
        avs_read       = 1'b1;
        wait_accept(acc, st);
        avs_read = 1'b0;
        n_rd++;
        for (int i = 0; i < eff_bc(bc); i++) begin
            t = (a + i) % ASPACE;
            exp_q.push_back((t >= DEPTH) ? 32'd0 : model_mem[t]);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        @(negedge clk);
        check("outstanding beats after drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int acc, st;
        int stl [5];
        for (int i = 0; i < ASPACE; i++) model_mem[i] = 32'd0;

        // Reset state
        #1;
        check("reset waitrequest", 32'(avs_waitrequest), 32'd1);
        check("reset readdatavalid", 32'(avs_readdatavalid), 32'd0);
        check("reset readdata", avs_readdata, 32'd0);
        check("reset rd_cmd_count", rd_cmd_count, 32'd0);
        check("reset wr_beat_count", wr_beat_count, 32'd0);
        check("reset err_oob", 32'(err_oob), 32'd0);
        check("reset err_proto", 32'(err_proto), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("waitrequest before first edge", 32'(avs_waitrequest), 32'd1);
        @(posedge clk);
        #1;
        check("waitrequest after first edge", 32'(avs_waitrequest), 32'd0);

        // Single write then single read
        wr(5, 32'hCAFE_0001, 4'hF, 4'd1);
        check("wr_beat_count after one write", wr_beat_count, 32'd1);
        rd(5, 4'd1, acc, st);
        drain();
        check("single read beats", 32'(got_q.size()), 32'd1);
        check("single read data", got_q[0], 32'hCAFE_0001);
        check("single read latency", 32'(got_cyc[0] - acc), 32'd2);
        check("rd_cmd_count after one read", rd_cmd_count, 32'd1);
        got_q.delete(); got_cyc.delete();

        // Background contents
        wr(0, 32'd0, 4'hF, 4'd1);
        for (int i = 0; i < 4; i++) wr(12 + i, 32'h100 + i, 4'hF, 4'd1);
        for (int i = 0; i < 5; i++) wr(20 + i, 32'h200 + i, 4'hF, 4'd1);
        wr(30, 32'd0, 4'hF, 4'd1);

        // Write burst of 4 at 8, later beats carry address 0
        wr(8, 32'd1, 4'hF, 4'd4);
        for (int i = 2; i <= 4; i++) wr(0, 32'(i), 4'hF, 4'd4);
        check("wr_beat_count after burst", wr_beat_count, 32'(n_wr));
        rd(8, 4'd4, acc, st);
        drain();
        check("burst read beats", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("burst read data", got_q[i], 32'(i + 1));
        check("burst beats contiguous", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
        got_q.delete(); got_cyc.delete();

        // Byte-enable merge
        wr(30, 32'hFFFF_FFFF, 4'b0101, 4'd1);
        rd(30, 4'd1, acc, st);
        drain();
        check("byteenable readback", got_q[0], 32'h00FF_00FF);
        got_q.delete(); got_cyc.delete();

        // Command FIFO fills behind a long burst
        rd(8, 4'd8, acc, st);
        check("burst8 stall cycles", 32'(st), 32'd0);
        for (int i = 0; i < 5; i++) rd(20 + i, 4'd1, acc, stl[i]);
        for (int i = 0; i < 4; i++) check("queued read stall cycles", 32'(stl[i]), 32'd0);
        check("fifth read stall cycles", 32'(stl[4]), 32'd3);
        drain();
        check("fifo test beats", 32'(got_q.size()), 32'd13);
        for (int i = 0; i < 5; i++) check("fifo test single data", got_q[8 + i], 32'h200 + 32'(i));
        check("rd_cmd_count after fifo test", rd_cmd_count, 32'(n_rd));
        got_q.delete(); got_cyc.delete();

        // Out-of-range and protocol errors
        check("err_oob before oob read", 32'(err_oob), 32'd0);
        rd(1023, 4'd2, acc, st);
        drain();
        check("oob burst beats", 32'(got_q.size()), 32'd2);
        check("oob beat0", got_q[0], 32'd0);
        check("oob beat1 wrapped", got_q[1], 32'd0);
        check("err_oob after oob read", 32'(err_oob), 32'd1);
        check("err_proto before bc0", 32'(err_proto), 32'd0);
        got_q.delete(); got_cyc.delete();
        rd(5, 4'd0, acc, st);
        drain();
        check("bc0 beats", 32'(got_q.size()), 32'd1);
        check("bc0 data", got_q[0], 32'hCAFE_0001);
        check("err_proto after bc0", 32'(err_proto), 32'd1);
        got_q.delete(); got_cyc.delete();

        // Reset in the middle of a read burst
        rd(12, 4'd8, acc, st);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid-reset readdatavalid", 32'(avs_readdatavalid), 32'd0);
        check("mid-reset rd_cmd_count", rd_cmd_count, 32'd0);
        check("mid-reset wr_beat_count", wr_beat_count, 32'd0);
        check("mid-reset err_oob", 32'(err_oob), 32'd0);
        check("mid-reset err_proto", 32'(err_proto), 32'd0);
        check("mid-reset waitrequest", 32'(avs_waitrequest), 32'd1);
        exp_q.delete(); got_q.delete(); got_cyc.delete();
        n_rd = 0; n_wr = 0; wb_left = 0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd(5, 4'd1, acc, st);
        drain();
        check("post-reset beats", 32'(got_q.size()), 32'd1);
        check("post-reset data retained", got_q[0], 32'hCAFE_0001);
        check("post-reset rd_cmd_count", rd_cmd_count, 32'd1);

        repeat (5) @(posedge clk);
        #1;
        check("final outstanding beats", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
